// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               fetch state encoding, instruction geometry, opcode values
//               that the control decoder also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // IDLE: no request, REQ: fetch_pc outstanding, DROP: stale request outstanding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch buffer of {pc, instr} entries. Slot 0 is always the
//               head, so the head outputs are plain storage and keep their
//               last contents once the buffer drains. Flush beats push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  r_pc        [DEPTH];
  logic [INSTR_W-1:0] r_instr     [DEPTH];
  logic [ADDR_W-1:0]  w_nxt_pc    [DEPTH];
  logic [INSTR_W-1:0] w_nxt_instr [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic               w_pop_ok;
  logic               w_push_ok;
  logic [CNT_W-1:0]   w_wr_slot;

  assign w_pop_ok  = pop & ~empty;
  // A push into a full buffer is only legal when the head leaves this cycle
  assign w_push_ok = push & (~full | w_pop_ok);
  // With a pop the whole queue moves up one slot, so the write lands one lower
  assign w_wr_slot = r_count - CNT_W'(w_pop_ok);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi < DEPTH - 1) begin : g_shift
      assign w_nxt_pc[gi]    = r_pc[gi+1];
      assign w_nxt_instr[gi] = r_instr[gi+1];
    end else begin : g_tail
      assign w_nxt_pc[gi]    = r_pc[gi];
      assign w_nxt_instr[gi] = r_instr[gi];
    end
  end

  // Storage and occupancy: shift toward the head on pop, write the new entry behind the last one
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (flush) begin
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push_ok && (w_wr_slot == CNT_W'(i))) begin
          r_pc[i]    <= push_pc;
          r_instr[i] <= push_instr;
        end else if (w_pop_ok && (CNT_W'(i + 1) < r_count)) begin
          r_pc[i]    <= w_nxt_pc[i];
          r_instr[i] <= w_nxt_instr[i];
        end
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  assign head_pc    = r_pc[0];
  assign head_instr = r_instr[0];
  assign count      = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches instruction words from instruction memory with at
//               most one request outstanding, buffers them with their PC and
//               hands them to decode. Branch redirect flushes the buffer and
//               drops any in-flight stale fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         instr_op_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);

  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] c_RESET_PC = RESET_PC & ~ADDR_W'(3);

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req;

  logic [ADDR_W-1:0]   w_head_pc;
  logic [INSTR_W-1:0]  w_head_instr;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_space;
  logic                w_room_after;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [ADDR_W-1:0]   w_drop_target;

  assign w_pop         = ~w_empty & instr_ready_i;
  assign w_redir_pc    = redirect_pc_i & ~ADDR_W'(3);
  assign w_pc_next     = r_fetch_pc + ADDR_W'(4);
  // A new request may start only when its reply is sure to find a slot
  assign w_space       = ~w_full | w_pop;
  // Room still left once this cycle's push and pop have both happened
  assign w_room_after  = (int'(w_count) + 1 - int'(w_pop)) < DEPTH;
  // In DROP the latest redirect wins, including one arriving with the ack
  assign w_drop_target = redirect_i ? w_redir_pc : r_fetch_pc;
  // Only a live (non-stale) reply without a redirect is kept
  assign w_push        = (r_state == ST_REQ) & imem_ack_i & ~redirect_i;

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (redirect_i),
    .push_pc    (r_fetch_pc),
    .push_instr (imem_data_i),
    .head_pc    (w_head_pc),
    .head_instr (w_head_instr),
    .count      (w_count),
    .full       (w_full),
    .empty      (w_empty)
  );

  // Fetch sequencer: issues requests, tracks the fetch PC and discards stale replies
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= c_RESET_PC;
      r_addr     <= c_RESET_PC;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
            r_addr     <= w_redir_pc;
            r_req      <= 1'b1;
            r_state    <= ST_REQ;
          end else if (w_space) begin
            r_addr  <= r_fetch_pc;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_ack_i && redirect_i) begin
            r_fetch_pc <= w_redir_pc;
            r_addr     <= w_redir_pc;
          end else if (imem_ack_i) begin
            r_fetch_pc <= w_pc_next;
            if (w_room_after) begin
              r_addr <= w_pc_next;
            end else begin
              r_req   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (redirect_i) begin
            // The memory still owns the old address; let it finish before moving on
            r_fetch_pc <= w_redir_pc;
            r_state    <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
          end
          if (imem_ack_i) begin
            r_addr  <= w_drop_target;
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = ~w_empty;
  assign instr_o       = w_head_instr;
  assign instr_op_o    = w_head_instr[OP_MSB:OP_LSB];
  assign pc_o          = w_head_pc;
  assign pc_plus4_o    = w_head_pc + ADDR_W'(4);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A memory responder
//               with programmable latency feeds the main instance; a second
//               instance with RESET_PC near the top of the address space runs
//               against a zero-wait memory. Delivered words are compared to
//               the program-order stream implied by the redirect history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  instr_op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        req_w;
  logic [31:0] addr_w;
  logic [31:0] data_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [5:0]  op_w;
  logic [31:0] pc_w;
  logic [31:0] pc4_w;

  int          n_asrt = 0;
  int          n_fail = 0;
  int          mem_wait;
  int          mem_lat;
  bit          lat_rand;
  int          n_xfer = 0;
  bit          prev_pending;
  logic [31:0] prev_addr;
  logic [31:0] last_ack_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_pc_w;
  logic [31:0] q_w[$];

  // Instruction memory contents: the three words of the directed program, a hash elsewhere
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0020;
      32'h0000_0004: return 32'h2008_0005;
      32'h0000_0008: return 32'h1000_0003;
      default:       return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endcase
  endfunction

  assign data_w = memword(addr_w);

  instr_fetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_op_o(instr_op), .pc_o(pc), .pc_plus4_o(pc_plus4),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  instr_fetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(req_w), .imem_addr_o(addr_w),
    .imem_ack_i(req_w), .imem_data_i(data_w),
    .instr_valid_o(valid_w), .instr_ready_i(1'b1),
    .instr_o(instr_w), .instr_op_o(op_w), .pc_o(pc_w), .pc_plus4_o(pc4_w),
    .redirect_i(1'b0), .redirect_pc_i(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: answer memory, score any transfer, advance to the next falling edge
  task automatic tick();
    logic [31:0] w;
    if (prev_pending) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, prev_addr);
    end
    if (imem_req) begin
      check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      if (mem_wait >= mem_lat) begin
        imem_ack      = 1'b1;
        imem_data     = memword(imem_addr);
        last_ack_addr = imem_addr;
        mem_wait      = 0;
        if (lat_rand) mem_lat = $urandom_range(0, 3);
      end else begin
        imem_ack  = 1'b0;
        imem_data = $urandom;
        mem_wait++;
      end
    end else begin
      imem_ack = 1'b0;
      mem_wait = 0;
    end
    prev_pending = imem_req && !imem_ack;
    prev_addr    = imem_addr;
    if (instr_valid && instr_ready) begin
      w = memword(exp_pc);
      check("xfer_pc", pc, exp_pc);
      check("xfer_instr", instr, w);
      check("xfer_op", 32'(instr_op), 32'(w[31:26]));
      check("xfer_pc4", pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (redirect) exp_pc = redirect_pc & ~32'd3;
    if (valid_w) begin
      w = memword(exp_pc_w);
      check("wrap_pc", pc_w, exp_pc_w);
      check("wrap_instr", instr_w, w);
      check("wrap_pc4", pc4_w, exp_pc_w + 32'd4);
      if (q_w.size() < 3) q_w.push_back(pc_w);
      exp_pc_w = exp_pc_w + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr_w", addr_w, 32'hFFFF_FFF8);
    exp_pc       = 32'h0;
    exp_pc_w     = 32'hFFFF_FFF8;
    mem_wait     = 0;
    prev_pending = 1'b0;
    q_w.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int          k;
    int          gaps;
    int          idle;
    int          x0;
    bit          acked;
    bit          seen_req;
    logic [31:0] first_addr;
    logic [31:0] resume_exp;
    logic [5:0]  ops[3];

    ops[0] = OP_RTYPE; ops[1] = OP_ADDI; ops[2] = OP_BEQ;
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; lat_rand = 1'b0; mem_lat = 0;
    @(negedge clk);

    // Step 1: zero-wait memory, three consecutive instructions
    instr_ready = 1'b1;
    do_reset();
    check("t1_req_before", 32'(imem_req), 32'd0);
    tick();
    check("t1_req_after", 32'(imem_req), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_pc", pc, 32'(i * 4));
      check("t1_op", 32'(instr_op), 32'(ops[i]));
      tick();
    end
    check("t6_wrap_count", 32'(q_w.size() >= 3), 32'd1);
    if (q_w.size() >= 3) begin
      check("t6_wrap0", q_w[0], 32'hFFFF_FFF8);
      check("t6_wrap1", q_w[1], 32'hFFFF_FFFC);
      check("t6_wrap2", q_w[2], 32'h0000_0000);
    end

    // Step 2: consumer stalls, buffer fills to DEPTH and fetch pauses
    instr_ready = 1'b0;
    repeat (10) tick();
    check("t2_req_low", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_buffered", (last_ack_addr + 32'd4 - exp_pc) >> 2, 32'd2);
    resume_exp  = last_ack_addr + 32'd4;
    instr_ready = 1'b1;
    gaps = 0; seen_req = 1'b0; first_addr = '0;
    for (int i = 0; i < 8; i++) begin
      if (!instr_valid) gaps++;
      if (imem_req && !seen_req) begin
        seen_req   = 1'b1;
        first_addr = imem_addr;
      end
      tick();
    end
    check("t2_resume_seen", 32'(seen_req), 32'd1);
    check("t2_resume_addr", first_addr, resume_exp);
    check("t2_gap", 32'(gaps <= 1), 32'd1);

    // Step 3: slow memory, redirect while the fetch of 0x4 is waiting
    mem_lat = 3;
    do_reset();
    k = 0;
    while (!(imem_req && imem_addr == 32'h4) && k < 30) begin tick(); k++; end
    check("t3_req4_seen", 32'(k < 30), 32'd1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    k = 0; acked = 1'b0;
    while (!acked && k < 10) begin
      check("t3_addr_hold", imem_addr, 32'h4);
      tick();
      acked = imem_ack;
      k++;
    end
    check("t3_ack_seen", 32'(acked), 32'd1);
    check("t3_next_req", 32'(imem_req), 32'd1);
    check("t3_next_addr", imem_addr, 32'h100);
    k = 0;
    while (!instr_valid && k < 20) begin tick(); k++; end
    check("t3_first_pc", pc, 32'h100);

    // Step 4: redirect in the same cycle as an ack, unaligned target
    mem_lat = 0;
    repeat (3) tick();
    check("t4_req_pre", 32'(imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    check("t4_ack", 32'(imem_ack), 32'd1);
    check("t4_empty", 32'(instr_valid), 32'd0);
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h100);
    repeat (3) tick();

    // Step 5: two redirects while a stale fetch is still outstanding
    mem_lat = 4;
    tick();
    check("t5_req_pre", 32'(imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    k = 0;
    while (!instr_valid && k < 30) begin tick(); k++; end
    check("t5_valid", 32'(instr_valid), 32'd1);
    check("t5_first_pc", pc, 32'h300);

    // Step 6: asynchronous reset while a request is waiting
    mem_lat = 0; instr_ready = 1'b0;
    repeat (3) tick();
    instr_ready = 1'b1;
    mem_lat = 5;
    tick();
    instr_ready = 1'b0;
    repeat (2) tick();
    check("t6_pre_req", 32'(imem_req), 32'd1);
    check("t6_pre_valid", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_req", 32'(imem_req), 32'd0);
    check("t6_async_addr", imem_addr, 32'h0);
    check("t6_async_valid", 32'(instr_valid), 32'd0);
    check("t6_async_instr", instr, 32'h0);
    check("t6_async_pc", pc, 32'h0);
    check("t6_async_addr_w", addr_w, 32'hFFFF_FFF8);
    @(negedge clk);

    // Random phase: random ready, latency and redirects against the program-order stream
    lat_rand = 1'b1;
    mem_lat  = $urandom_range(0, 3);
    do_reset();
    x0 = n_xfer; idle = 0;
    for (int i = 0; i < 3000; i++) begin
      k = n_xfer;
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                                : ($urandom & 32'h3FFF);
      tick();
      if (n_xfer != k) idle = 0;
      else idle++;
      if (idle > 60) break;
    end
    redirect = 1'b0;
    check("rand_live", 32'(idle <= 60), 32'd1);
    check("rand_progress", 32'((n_xfer - x0) > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
